// File: rtl/true_form_pkg.sv
`default_nettype none
// ============================================================================
// Module : true_form_pkg
// Purpose: Shared types and helpers for the bit-serial sign-magnitude
//          subtractor: controller states, serial ALU modes, counter sizing
//          and the negative-zero suppression rule.
// Ports  : (package, none)
// Rev    : 1.0  initial release
// ============================================================================
package true_form_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_NEG = 2'd2
  } alu_mode_e;

  // Bit-counter width for a WIDTH-bit word: enough to count M = WIDTH-1
  // magnitude bits, never narrower than one bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width - 1);
    return (w < 1) ? 1 : w;
  endfunction

  // A zero magnitude keeps a positive sign unless it is the wrapped result
  // of an overflow, where the operand sign is preserved.
  function automatic logic sm_neg_zero_fix(input logic sign,
                                           input logic nonzero,
                                           input logic of);
    return sign & (nonzero | of);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_bit_alu.sv
`default_nettype none
// ============================================================================
// Module : serial_bit_alu
// Purpose: One-bit full adder / subtractor / negator with a registered
//          carry (or borrow). Used LSB first, one bit per enabled cycle.
// Ports  : clk, rst      - clock, synchronous active-high reset
//          en_i          - store the carry-out for the next bit
//          clear_i       - force the stored carry to 0 (start add/sub)
//          preset_i      - force the stored carry to 1 (start negate)
//          mode_i        - ALU_ADD, ALU_SUB or ALU_NEG
//          a_bit_i       - operand A bit (or the bit being negated)
//          b_bit_i       - operand B bit (ignored in ALU_NEG)
//          r_bit_o       - result bit for the current position
//          c_next_o      - carry/borrow out of the current position
// Rev    : 1.0  initial release
// ============================================================================
module serial_bit_alu
  import true_form_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       clear_i,
  input  logic       preset_i,
  input  logic [1:0] mode_i,
  input  logic       a_bit_i,
  input  logic       b_bit_i,
  output logic       r_bit_o,
  output logic       c_next_o
);

  logic c_q;

  always_comb begin
    r_bit_o  = 1'b0;
    c_next_o = 1'b0;
    case (mode_i)
      ALU_ADD: begin
        r_bit_o  = a_bit_i ^ b_bit_i ^ c_q;
        c_next_o = (a_bit_i & b_bit_i) | (c_q & (a_bit_i ^ b_bit_i));
      end
      ALU_SUB: begin
        r_bit_o  = a_bit_i ^ b_bit_i ^ c_q;
        c_next_o = (~a_bit_i & b_bit_i) | (c_q & ~(a_bit_i ^ b_bit_i));
      end
      ALU_NEG: begin
        // Two's-complement negate: invert and add the carry seeded with 1.
        r_bit_o  = ~a_bit_i ^ c_q;
        c_next_o = ~a_bit_i & c_q;
      end
      default: begin
        r_bit_o  = 1'b0;
        c_next_o = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= 1'b0;
    end else if (clear_i) begin
      c_q <= 1'b0;
    end else if (preset_i) begin
      c_q <= 1'b1;
    end else if (en_i) begin
      c_q <= c_next_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/true_form_sub_serial.sv
`default_nettype none
// ============================================================================
// Module : true_form_sub_serial
// Purpose: Bit-serial sign-magnitude subtractor S = A - B. One magnitude bit
//          per cycle, LSB first; a negative raw difference is corrected by a
//          serial two's-complement pass over the stored magnitude.
// Ports  : clk, rst            - clock, synchronous active-high reset
//          in_valid / in_ready - operand handshake (A, B)
//          A, B                - sign-magnitude minuend / subtrahend
//          out_valid/out_ready - result handshake (S, OF)
//          S                   - sign-magnitude difference
//          OF                  - magnitude overflow (effective addition)
// Rev    : 1.0  initial release
// ============================================================================
module true_form_sub_serial
  import true_form_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             OF
);

  localparam int M  = WIDTH - 1;
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  state_e         state_q;
  logic [M-1:0]   mag_a_q;
  logic [M-1:0]   mag_b_q;
  logic [M-1:0]   res_q;
  logic [CW-1:0]  cnt_q;
  logic           sign_a_q;
  logic           sign_bp_q;
  logic           eff_diff_q;
  logic           nz_q;
  logic [WIDTH-1:0] s_q;
  logic           of_q;

  logic           alu_en;
  logic           alu_clear;
  logic           alu_preset;
  logic [1:0]     alu_mode;
  logic           alu_a;
  logic           alu_b;
  logic           r_bit;
  logic           c_next;

  logic [M:0]     res_ext;
  logic [M-1:0]   res_d;
  logic           nz_d;
  logic           last;
  logic           need_fix;
  logic           of_d;

  // Result bits enter at the top, so after M shifts the word is aligned.
  assign res_ext  = {r_bit, res_q};
  assign res_d    = res_ext[M:1];
  assign nz_d     = nz_q | r_bit;
  assign last     = (cnt_q == LAST);
  assign need_fix = eff_diff_q & c_next;
  assign of_d     = ~eff_diff_q & c_next;

  always_comb begin
    alu_en     = (state_q == RUN) || (state_q == FIX);
    alu_clear  = (state_q == IDLE);
    // Seed the negation carry in place of storing the final borrow.
    alu_preset = (state_q == RUN) && last && need_fix;
    alu_mode   = ALU_ADD;
    alu_a      = mag_a_q[0];
    alu_b      = mag_b_q[0];
    if (state_q == FIX) begin
      alu_mode = ALU_NEG;
      alu_a    = res_q[0];
    end else if (eff_diff_q) begin
      alu_mode = ALU_SUB;
    end
  end

  serial_bit_alu u_alu (
    .clk      (clk),
    .rst      (rst),
    .en_i     (alu_en),
    .clear_i  (alu_clear),
    .preset_i (alu_preset),
    .mode_i   (alu_mode),
    .a_bit_i  (alu_a),
    .b_bit_i  (alu_b),
    .r_bit_o  (r_bit),
    .c_next_o (c_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      sign_a_q   <= 1'b0;
      sign_bp_q  <= 1'b0;
      eff_diff_q <= 1'b0;
      nz_q       <= 1'b0;
      s_q        <= '0;
      of_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mag_a_q    <= A[M-1:0];
            mag_b_q    <= B[M-1:0];
            sign_a_q   <= A[WIDTH-1];
            sign_bp_q  <= ~B[WIDTH-1];
            eff_diff_q <= A[WIDTH-1] ^ ~B[WIDTH-1];
            res_q      <= '0;
            nz_q       <= 1'b0;
            cnt_q      <= '0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          mag_a_q <= mag_a_q >> 1;
          mag_b_q <= mag_b_q >> 1;
          res_q   <= res_d;
          nz_q    <= nz_d;
          cnt_q   <= cnt_q + 1'b1;
          if (last) begin
            cnt_q <= '0;
            if (need_fix) begin
              nz_q    <= 1'b0;
              state_q <= FIX;
            end else begin
              s_q     <= {sm_neg_zero_fix(sign_a_q, nz_d, of_d), res_d};
              of_q    <= of_d;
              state_q <= DONE;
            end
          end
        end
        FIX: begin
          res_q <= res_d;
          nz_q  <= nz_d;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            cnt_q   <= '0;
            s_q     <= {sm_neg_zero_fix(sign_bp_q, nz_d, 1'b0), res_d};
            of_q    <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign S         = s_q;
  assign OF        = of_q;

endmodule
`default_nettype wire

// File: tb/tb_true_form_sub_serial.sv
`default_nettype none
// ============================================================================
// Module : tb_true_form_sub_serial
// Purpose: Directed scoreboard bench for the serial sign-magnitude
//          subtractor (WIDTH=4).
// Rev    : 1.0  initial release
// ============================================================================
module tb_true_form_sub_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] A;
  logic [3:0] B;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] S;
  logic       OF;

  true_form_sub_serial #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .OF        (OF)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] s;
    logic       of;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: checks latency on the rising edge of out_valid and the result
  // on every accepted output beat.
  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (out_valid && !prev) begin
          chk("valid_expected", sb.size() != 0, 1);
          if (sb.size() != 0) chk("latency", cyc - sb[0].acc, sb[0].lat);
        end
        if (out_valid && out_ready) begin
          chk("result_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("S", S, e.s);
            chk("OF", OF, e.of);
          end
        end
        prev = out_valid;
      end
    end
  end

  task automatic send(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] es, input logic eof,
                      input int lat, input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) sb.push_back('{es, eof, lat, cyc});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin : stim
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_S", S, 0);
    chk("rst_OF", OF, 0);
    rst = 1'b0;

    send(4'b0101, 4'b0011, 4'b0010, 1'b0, 3, 1'b1); drain();  // +5 - +3
    send(4'b0011, 4'b0101, 4'b1010, 1'b0, 6, 1'b1); drain();  // +3 - +5
    send(4'b1011, 4'b0101, 4'b1000, 1'b1, 3, 1'b1); drain();  // -3 - +5
    send(4'b0100, 4'b0100, 4'b0000, 1'b0, 3, 1'b1); drain();  // +4 - +4
    send(4'b1000, 4'b0000, 4'b0000, 1'b0, 3, 1'b1); drain();  // -0 - +0
    send(4'b1101, 4'b1011, 4'b1010, 1'b0, 3, 1'b1); drain();  // -5 - -3
    send(4'b0111, 4'b1001, 4'b0000, 1'b1, 3, 1'b1); drain();  // +7 - -1

    // Backpressure in DONE with competing operands offered.
    out_ready = 1'b0;
    send(4'b0101, 4'b0011, 4'b0010, 1'b0, 3, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      A = 4'b0111;
      B = 4'b0001;
      in_valid = 1'b1;
      chk("bp_S_hold", S, 4'b0010);
      chk("bp_OF_hold", OF, 0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("bp_no_extra", out_valid, 0);
    chk("bp_sb_empty", sb.size(), 0);

    // Reset while in the correction pass of +3 - +5.
    send(4'b0011, 4'b0101, 4'b1010, 1'b0, 6, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_S", S, 0);
    chk("mid_rst_OF", OF, 0);
    rst = 1'b0;
    send(4'b0101, 4'b0011, 4'b0010, 1'b0, 3, 1'b1); drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
